// File: rtl/cnn_host_ctrl.sv
// cnn_host_ctrl: host-side sequencer for the cnn accelerator.
// Streams LOAD_WORDS input words into the IF1 BRAM, pulses cnn_start, waits for
// cnn_done (bounded by DONE_TIMEOUT) and streams RESULT_WORDS words back out of
// the result BRAM. All outputs are registered; outputs are decoded from the next state.
//
// state   | meaning
// IDLE    | no run in progress, waiting for go
// LOAD    | accepting input words, one IF1 write per handshake
// START   | one-cycle cnn_start pulse after the final IF1 write
// WAIT    | waiting for cnn_done, timer running
// RD_REQ  | result BRAM read issued for word r
// RD_DATA | BRAM read data captured into out_data
// OUT     | out_valid held until the sink takes word r
// ERR     | cnn_done timed out, error held until next go
module cnn_host_ctrl #(
    parameter int          LOAD_WORDS   = 256,
    parameter int          RESULT_WORDS = 21,
    parameter logic [31:0] LOAD_BASE    = 32'h0,
    parameter logic [31:0] RES_BASE     = 32'h0,
    parameter int          DONE_TIMEOUT = 1048576
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        go,
    input  logic        in_valid,
    output logic        in_ready,
    input  logic [31:0] in_data,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [31:0] out_data,
    output logic        out_last,
    output logic        busy,
    output logic        error,
    output logic        cnn_start,
    input  logic        cnn_done,
    output logic [31:0] BRAM_L_ADDR,
    output logic        BRAM_L_EN,
    output logic [3:0]  BRAM_L_WE,
    output logic [31:0] BRAM_L_DIN,
    output logic [31:0] BRAM_R_ADDR,
    output logic        BRAM_R_EN,
    output logic [3:0]  BRAM_R_WE,
    input  logic [31:0] BRAM_R_DOUT
);

    localparam int MAXW = (LOAD_WORDS > RESULT_WORDS) ? LOAD_WORDS : RESULT_WORDS;
    localparam int CW   = $clog2(MAXW + 1);
    localparam int TW   = $clog2(DONE_TIMEOUT + 1);
    localparam logic [CW-1:0] K_LAST = CW'(LOAD_WORDS - 1);
    localparam logic [CW-1:0] R_LAST = CW'(RESULT_WORDS - 1);
    localparam logic [TW-1:0] T_LAST = TW'(DONE_TIMEOUT - 1);

    typedef enum logic [2:0] {
        IDLE, LOAD, START, WAIT, RD_REQ, RD_DATA, OUT, ERR
    } state_t;

    state_t        state_q, state_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic [TW-1:0] timer_q, timer_d;
    logic          in_ready_q, in_ready_d;
    logic          out_valid_q, out_valid_d;
    logic          out_last_q, out_last_d;
    logic [31:0]   out_data_q, out_data_d;
    logic          busy_q, busy_d;
    logic          error_q, error_d;
    logic          cnn_start_q, cnn_start_d;
    logic          bram_l_en_q, bram_l_en_d;
    logic [3:0]    bram_l_we_q, bram_l_we_d;
    logic [31:0]   bram_l_addr_q, bram_l_addr_d;
    logic [31:0]   bram_l_din_q, bram_l_din_d;
    logic          bram_r_en_q, bram_r_en_d;
    logic [31:0]   bram_r_addr_q, bram_r_addr_d;

    // Next-state, counters and next values of every registered output.
    always_comb begin
        state_d       = state_q;
        cnt_d         = cnt_q;
        timer_d       = timer_q;
        error_d       = error_q;
        out_data_d    = out_data_q;
        bram_l_en_d   = 1'b0;
        bram_l_we_d   = 4'h0;
        bram_l_addr_d = bram_l_addr_q;
        bram_l_din_d  = bram_l_din_q;
        bram_r_en_d   = 1'b0;
        bram_r_addr_d = bram_r_addr_q;

        unique case (state_q)
            IDLE, ERR: begin
                if (go) begin
                    state_d = LOAD;
                    cnt_d   = '0;
                    error_d = 1'b0;
                end
            end
            LOAD: begin
                if (in_valid && in_ready_q) begin
                    bram_l_en_d   = 1'b1;
                    bram_l_we_d   = 4'hF;
                    bram_l_addr_d = LOAD_BASE + (32'(cnt_q) << 2);
                    bram_l_din_d  = in_data;
                    if (cnt_q == K_LAST) begin
                        state_d = START;
                    end else begin
                        cnt_d = cnt_q + 1'b1;
                    end
                end
            end
            START: begin
                state_d = WAIT;
                timer_d = '0;
            end
            WAIT: begin
                if (cnn_done) begin
                    state_d = RD_REQ;
                    cnt_d   = '0;
                end else if (timer_q == T_LAST) begin
                    state_d = ERR;
                    error_d = 1'b1;
                end else begin
                    timer_d = timer_q + 1'b1;
                end
            end
            RD_REQ: begin
                state_d = RD_DATA;
            end
            RD_DATA: begin
                out_data_d = BRAM_R_DOUT;
                state_d    = OUT;
            end
            OUT: begin
                if (out_ready) begin
                    if (cnt_q == R_LAST) begin
                        state_d = IDLE;
                    end else begin
                        cnt_d   = cnt_q + 1'b1;
                        state_d = RD_REQ;
                    end
                end
            end
            default: state_d = IDLE;
        endcase

        // Read request is registered so it is on the port during the RD_REQ cycle.
        if (state_d == RD_REQ) begin
            bram_r_en_d   = 1'b1;
            bram_r_addr_d = RES_BASE + (32'(cnt_d) << 2);
        end

        in_ready_d  = (state_d == LOAD);
        cnn_start_d = (state_d == START);
        out_valid_d = (state_d == OUT);
        out_last_d  = (state_d == OUT) && (cnt_d == R_LAST);
        busy_d      = (state_d != IDLE) && (state_d != ERR);
    end

    // State and output registers with synchronous active-low reset.
    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q       <= IDLE;
            cnt_q         <= '0;
            timer_q       <= '0;
            in_ready_q    <= 1'b0;
            out_valid_q   <= 1'b0;
            out_last_q    <= 1'b0;
            out_data_q    <= '0;
            busy_q        <= 1'b0;
            error_q       <= 1'b0;
            cnn_start_q   <= 1'b0;
            bram_l_en_q   <= 1'b0;
            bram_l_we_q   <= 4'h0;
            bram_l_addr_q <= '0;
            bram_l_din_q  <= '0;
            bram_r_en_q   <= 1'b0;
            bram_r_addr_q <= '0;
        end else begin
            state_q       <= state_d;
            cnt_q         <= cnt_d;
            timer_q       <= timer_d;
            in_ready_q    <= in_ready_d;
            out_valid_q   <= out_valid_d;
            out_last_q    <= out_last_d;
            out_data_q    <= out_data_d;
            busy_q        <= busy_d;
            error_q       <= error_d;
            cnn_start_q   <= cnn_start_d;
            bram_l_en_q   <= bram_l_en_d;
            bram_l_we_q   <= bram_l_we_d;
            bram_l_addr_q <= bram_l_addr_d;
            bram_l_din_q  <= bram_l_din_d;
            bram_r_en_q   <= bram_r_en_d;
            bram_r_addr_q <= bram_r_addr_d;
        end
    end

    assign in_ready    = in_ready_q;
    assign out_valid   = out_valid_q;
    assign out_last    = out_last_q;
    assign out_data    = out_data_q;
    assign busy        = busy_q;
    assign error       = error_q;
    assign cnn_start   = cnn_start_q;
    assign BRAM_L_EN   = bram_l_en_q;
    assign BRAM_L_WE   = bram_l_we_q;
    assign BRAM_L_ADDR = bram_l_addr_q;
    assign BRAM_L_DIN  = bram_l_din_q;
    assign BRAM_R_EN   = bram_r_en_q;
    assign BRAM_R_ADDR = bram_r_addr_q;
    assign BRAM_R_WE   = 4'h0;

endmodule

// File: tb/tb_cnn_host_ctrl.sv
// tb_cnn_host_ctrl: directed sequence of runs with randomized data, valid gaps
// and sink stalls, checked against a word-level model of the load/readback.
module tb_cnn_host_ctrl;
    localparam int          LW = 4;
    localparam int          RW = 3;
    localparam int          TO = 64;
    localparam logic [31:0] LB = 32'h0;
    localparam logic [31:0] RB = 32'hFFFF_FFF8;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        go = 1'b0;
    logic        in_valid = 1'b0;
    logic        out_ready = 1'b0;
    logic        cnn_done = 1'b0;
    logic [31:0] in_data = '0;
    logic        in_ready, out_valid, out_last, busy, error, cnn_start;
    logic [31:0] out_data;
    logic [31:0] bram_l_addr, bram_l_din, bram_r_addr;
    logic [31:0] bram_r_dout = '0;
    logic        bram_l_en, bram_r_en;
    logic [3:0]  bram_l_we, bram_r_we;

    int n_total = 0;
    int n_pass  = 0;
    int n_fail  = 0;
    int cyc     = 0;
    int start_cnt = 0;

    logic [31:0] res_mem [RW];
    logic [31:0] words   [LW];
    logic [31:0] wr_addr [$];
    logic [31:0] wr_data [$];
    logic [3:0]  wr_we   [$];
    int          wr_cyc  [$];
    logic [31:0] rd_addr [$];

    cnn_host_ctrl #(
        .LOAD_WORDS(LW), .RESULT_WORDS(RW), .LOAD_BASE(LB),
        .RES_BASE(RB), .DONE_TIMEOUT(TO)
    ) dut (
        .clk(clk), .rst(rst), .go(go),
        .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
        .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data), .out_last(out_last),
        .busy(busy), .error(error), .cnn_start(cnn_start), .cnn_done(cnn_done),
        .BRAM_L_ADDR(bram_l_addr), .BRAM_L_EN(bram_l_en), .BRAM_L_WE(bram_l_we), .BRAM_L_DIN(bram_l_din),
        .BRAM_R_ADDR(bram_r_addr), .BRAM_R_EN(bram_r_en), .BRAM_R_WE(bram_r_we), .BRAM_R_DOUT(bram_r_dout)
    );

    always #5 clk = ~clk;

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    function automatic logic [31:0] res_rd(input logic [31:0] a);
        logic [31:0] off;
        off = a - RB;
        if (off[1:0] == 2'b00 && (off >> 2) < RW) return res_mem[int'(off >> 2)];
        return 32'hDEAD_0000 ^ a;
    endfunction

    // IF1 write log, result BRAM model, start pulse counter
    always @(posedge clk) begin
        cyc <= cyc + 1;
        if (bram_l_en) begin
            wr_addr.push_back(bram_l_addr);
            wr_data.push_back(bram_l_din);
            wr_we.push_back(bram_l_we);
            wr_cyc.push_back(cyc);
        end
        if (bram_r_en) begin
            rd_addr.push_back(bram_r_addr);
            bram_r_dout <= res_rd(bram_r_addr);
        end
        if (cnn_start) start_cnt++;
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_total++;
        assert (obs === exp) n_pass++;
        else begin
            n_fail++;
            $error("FAIL %s observed=0x%08h expected=0x%08h", tag, obs, exp);
        end
    endtask

    task automatic check_reset_outputs(input string tag);
        chk({tag, "_flags"}, 32'({in_ready, out_valid, out_last, busy, error, cnn_start, bram_l_en, bram_r_en}), 32'h0);
        chk({tag, "_l_we"}, 32'(bram_l_we), 32'h0);
        chk({tag, "_l_addr"}, bram_l_addr, 32'h0);
        chk({tag, "_l_din"}, bram_l_din, 32'h0);
        chk({tag, "_r_addr"}, bram_r_addr, 32'h0);
        chk({tag, "_out_data"}, out_data, 32'h0);
        chk({tag, "_r_we"}, 32'(bram_r_we), 32'h0);
    endtask

    task automatic prep(input bit fixed);
        wr_addr.delete(); wr_data.delete(); wr_we.delete(); wr_cyc.delete(); rd_addr.delete();
        start_cnt = 0;
        for (int i = 0; i < LW; i++) words[i] = fixed ? 32'h11 * 32'(i + 1) : $urandom;
        for (int i = 0; i < RW; i++) res_mem[i] = fixed ? 32'hA + 32'(i) : $urandom;
    endtask

    task automatic pulse_go();
        go = 1'b1;
        @(negedge clk);
        go = 1'b0;
    endtask

    // Streams the model's words with the chosen valid pattern; returns in the START cycle.
    task automatic load(input int mode);
        int sent  = 0;
        int steps = 0;
        bit hs;
        while (sent < LW && steps < 200) begin
            case (mode)
                0:       in_valid = 1'b1;
                1:       in_valid = (steps % 2 == 0);
                default: in_valid = 1'($urandom_range(0, 1));
            endcase
            in_data = in_valid ? words[sent] : $urandom;
            hs = in_valid && in_ready;
            @(negedge clk);
            if (hs) sent++;
            steps++;
        end
        in_valid = 1'b0;
        chk("load_words_accepted", sent, LW);
        chk("in_ready_after_last", 32'(in_ready), 32'h0);
        chk("busy_after_last", 32'(busy), 32'h1);
    endtask

    task automatic check_writes(input int mode);
        chk("wr_count", wr_addr.size(), LW);
        for (int i = 0; i < LW && i < wr_addr.size(); i++) begin
            chk($sformatf("wr_addr%0d", i), wr_addr[i], LB + 32'(4 * i));
            chk($sformatf("wr_data%0d", i), wr_data[i], words[i]);
            chk($sformatf("wr_we%0d", i), 32'(wr_we[i]), 32'hF);
            if (mode == 0 && i > 0) chk($sformatf("wr_b2b%0d", i), wr_cyc[i] - wr_cyc[i-1], 1);
        end
    endtask

    task automatic wait_read(input int mode, input int delay, input bit done_in_start,
                             input int stall_word, input int stall_len, input int abort_at);
        bit          early = 1'b0;
        bit          stable;
        int          n;
        int          stall;
        logic [31:0] held;
        if (done_in_start) cnn_done = 1'b1;
        for (int i = 0; i < delay; i++) begin
            @(negedge clk);
            cnn_done = 1'b0;
            go = (i == 3);
            if (bram_r_en || out_valid || !busy) early = 1'b1;
        end
        go = 1'b0;
        chk("no_read_before_done", 32'(early), 32'h0);
        chk("single_start_pulse", start_cnt, 1);
        check_writes(mode);
        cnn_done = 1'b1;
        @(negedge clk);
        cnn_done = 1'b0;
        chk("rd_req_after_done", 32'(bram_r_en), 32'h1);
        chk("rd_addr_first", bram_r_addr, RB);
        for (int r = 0; r < RW; r++) begin
            n = 0;
            while (!out_valid && n < 10) begin
                @(negedge clk);
                n++;
            end
            chk($sformatf("out_valid_w%0d", r), 32'(out_valid), 32'h1);
            if (r == abort_at) begin
                rst = 1'b0;
                @(negedge clk);
                rst = 1'b1;
                check_reset_outputs("rst_mid_out");
                return;
            end
            chk($sformatf("out_data_w%0d", r), out_data, res_mem[r]);
            chk($sformatf("out_last_w%0d", r), 32'(out_last), 32'(r == RW - 1));
            stall  = (r == stall_word) ? stall_len : int'($urandom_range(0, 2));
            held   = out_data;
            stable = 1'b1;
            for (int s = 0; s < stall; s++) begin
                @(negedge clk);
                if (out_data !== held || out_valid !== 1'b1 || out_last !== (r == RW - 1)) stable = 1'b0;
            end
            chk($sformatf("out_hold_w%0d", r), 32'(stable), 32'h1);
            out_ready = 1'b1;
            @(negedge clk);
            out_ready = 1'b0;
        end
        chk("busy_after_run", 32'(busy), 32'h0);
        chk("out_valid_after_run", 32'(out_valid), 32'h0);
        chk("rd_count", rd_addr.size(), RW);
        for (int r = 0; r < RW && r < rd_addr.size(); r++)
            chk($sformatf("rd_addr%0d", r), rd_addr[r], RB + 32'(4 * r));
    endtask

    task automatic run(input bit fixed, input int mode, input bit done_in_start,
                       input int stall_word, input int stall_len, input int abort_at);
        prep(fixed);
        pulse_go();
        chk("in_ready_in_load", 32'(in_ready), 32'h1);
        chk("busy_in_load", 32'(busy), 32'h1);
        load(mode);
        wait_read(mode, 50, done_in_start, stall_word, stall_len, abort_at);
    endtask

    initial begin
        int n;
        int n_wait;

        repeat (3) @(negedge clk);
        check_reset_outputs("reset");
        rst = 1'b1;
        @(negedge clk);

        // stray input traffic while idle
        prep(1'b0);
        in_valid = 1'b1;
        in_data  = 32'h5555_AAAA;
        repeat (3) @(negedge clk);
        in_valid = 1'b0;
        @(negedge clk);
        chk("idle_in_ready", 32'(in_ready), 32'h0);
        chk("idle_no_writes", wr_addr.size(), 0);

        run(1'b1, 0, 1'b1, 1, 5, -1);
        run(1'b0, 1, 1'b0, -1, 0, -1);

        // cnn_done never arrives
        prep(1'b0);
        pulse_go();
        load(0);
        n = 0;
        n_wait = 0;
        while (!error && n < 3 * TO) begin
            @(negedge clk);
            n++;
            if (!error && busy) n_wait++;
        end
        chk("timeout_wait_cycles", n_wait, TO);
        chk("timeout_error", 32'(error), 32'h1);
        chk("timeout_busy", 32'(busy), 32'h0);
        chk("timeout_no_read", 32'(bram_r_en), 32'h0);
        check_writes(0);
        pulse_go();
        chk("err_go_clears", 32'(error), 32'h0);
        chk("err_go_load", 32'(in_ready), 32'h1);

        // reset in the middle of a load, with a handshake pending at the reset edge
        in_valid = 1'b1;
        in_data  = 32'h1234_5678;
        repeat (2) @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        rst = 1'b1;
        in_valid = 1'b0;
        check_reset_outputs("rst_mid_load");

        run(1'b0, 2, 1'b0, 0, 3, -1);
        run(1'b0, 0, 1'b0, -1, 0, 1);
        run(1'b0, 2, 1'b0, 2, 4, -1);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end
endmodule
